// File: rtl/acc_seq_alu.sv
// Accumulator ALU behind the operand select mux.
// LOAD/ADD/SUB finish in one cycle; MUL is an unsigned shift-add over WIDTH cycles.
module acc_seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf
);

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic               ovf_q, ovf_nxt;
    logic               vld_q, vld_nxt;
    logic               rdy_q, rdy_nxt;
    logic [2*WIDTH-1:0] mcand, mcand_nxt;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod_step;

    assign sum       = acc + in_data;
    assign diff      = acc - in_data;
    assign prod_step = prod + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        ovf_nxt    = ovf_q;
        vld_nxt    = 1'b0;
        mcand_nxt  = mcand;
        prod_nxt   = prod;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    unique case (op)
                        OP_LOAD: begin
                            acc_nxt = in_data;
                            ovf_nxt = 1'b0;
                            vld_nxt = 1'b1;
                        end
                        OP_ADD: begin
                            acc_nxt = sum;
                            ovf_nxt = (acc[WIDTH-1] == in_data[WIDTH-1]) &&
                                      (sum[WIDTH-1] != acc[WIDTH-1]);
                            vld_nxt = 1'b1;
                        end
                        OP_SUB: begin
                            acc_nxt = diff;
                            ovf_nxt = (acc[WIDTH-1] != in_data[WIDTH-1]) &&
                                      (diff[WIDTH-1] != acc[WIDTH-1]);
                            vld_nxt = 1'b1;
                        end
                        OP_MUL: begin
                            mcand_nxt  = {{WIDTH{1'b0}}, acc};
                            mplier_nxt = in_data;
                            prod_nxt   = '0;
                            cnt_nxt    = '0;
                            state_nxt  = MUL;
                        end
                    endcase
                end
            end
            MUL: begin
                prod_nxt   = prod_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 1'b1;
                // The last iteration commits straight from the adder output.
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    acc_nxt   = prod_step[WIDTH-1:0];
                    ovf_nxt   = |prod_step[2*WIDTH-1:WIDTH];
                    vld_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
        rdy_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b1;
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            ovf_q  <= ovf_nxt;
            vld_q  <= vld_nxt;
            rdy_q  <= rdy_nxt;
            mcand  <= mcand_nxt;
            prod   <= prod_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = acc;
    assign ovf       = ovf_q;

endmodule
